hazard_unit: RTL
================

# hazard_unit

Pipeline hazard controller for the 5-stage ARM-subset core. It consumes the condition-gated results that the condition unit produces in Execute (BranchTakenE, PCSrcM) together with register addresses from Decode, Execute, Memory and Writeback. It drives the forwarding selects and the stall/flush controls back into the pipeline registers. It owns a small state machine that tracks in-flight non-branch PC writes, so fetch is held until the new PC is resolved.

## Interface
Parameters:
- REGW, default 4: register-address width.
- CNTW, default 32: width of the performance counters (used only with HAZARD_PERF_EN).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- RA1D, RA2D  in  REGW  source registers of the instruction in Decode.
- RA1E, RA2E  in  REGW  source registers of the instruction in Execute.
- WA3E, WA3M, WA3W  in  REGW  destination registers in Execute, Memory and Writeback.
- RegWriteM, RegWriteW  in  1  condition-gated register write in Memory and Writeback.
- MemtoRegE  in  1  the instruction in Execute is a load.
- PCSrcD  in  1  the instruction in Decode writes R15 through the register path. It is never asserted for B/BL.
- PCSrcM  in  1  condition-gated PC write in Memory, from the condition unit.
- BranchTakenE  in  1  condition-gated taken branch in Execute.
- ForwardAE, ForwardBE  out  2  operand selects: 00 = register file, 01 = Writeback result, 10 = Memory ALU result.
- StallF, StallD  out  1  hold the PC register and the D pipeline register.
- FlushD, FlushE  out  1  clear the D and E pipeline registers to a bubble.
- StallCount, FlushCount  out  CNTW  performance counters. Present only with HAZARD_PERF_EN.

## Operation
- Forwarding (per operand, RA1E→ForwardAE and RA2E→ForwardBE):
  - 10 if RegWriteM and RAxE==WA3M;
  - else 01 if RegWriteW and RAxE==WA3W;
  - else 00.
  - Memory wins when Memory and Writeback both match.
  - RAxE==4'hF (R15) never forwards; the select is 00.
- Load-use: ldrStall = MemtoRegE & (RA1D==WA3E | RA2D==WA3E) & (state==IDLE).
- PC-write FSM (pcw_state), with states IDLE, PCW_E, PCW_M, PCW_W:
  - IDLE→PCW_E when PCSrcD & ~ldrStall & ~BranchTakenE.
  - PCW_E→PCW_M unconditionally.
  - PCW_M→PCW_W if PCSrcM, else →IDLE (condition failed; PC is not written).
  - PCW_W→IDLE.
- pcwPend = (state!=IDLE) | (state==IDLE & PCSrcD & ~BranchTakenE).
- Output equations:
  - StallD = ldrStall & ~BranchTakenE.
  - StallF = (ldrStall | (pcwPend & state!=PCW_W)) & ~BranchTakenE.
  - FlushD = pcwPend | BranchTakenE.
  - FlushE = ldrStall | BranchTakenE.
- Priority: BranchTakenE overrides every stall. The Decode instruction is flushed, so no load-use stall is needed.
- While reset is low: state=IDLE, StallF=StallD=0, FlushD=FlushE=1, ForwardAE=ForwardBE=00, counters=0.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the registered pcw_state. There are no flops on the output path.
- An accepted PC write holds fetch for three cycles. With cycle 0 as PCSrcD in IDLE:
  - cycles 0–2: StallF=1, FlushD=1;
  - cycle 3 (PCW_W): StallF=0, so the PC loads the Writeback result, and FlushD=1;
  - cycle 4: normal operation.
- If PCSrcM=0 in cycle 2, cycle 3 is IDLE and fetch resumes with the PC unchanged.
- A load-use stall in cycle 0 defers acceptance. The FSM stays IDLE and PCSrcD is re-evaluated next cycle.
- Reset deasserting mid-sequence: the FSM restarts from IDLE. There is no recovery of an in-flight PC write; the pipeline is flushed during reset.

## Configuration
- HAZARD_PERF_EN defined:
  - StallCount increments on every cycle with StallD=1.
  - FlushCount increments on every cycle with FlushE=1.
  - Both counters are CNTW bits, saturate at all-ones and clear on reset.
- HAZARD_PERF_EN undefined: the counter ports and logic are absent, and the stall/flush behaviour is identical.

## Structure
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - pcw_state_t enum: IDLE, PCW_E, PCW_M, PCW_W;
  - constant PC_REG=4'hF.
- One sub-module, fwd_select (one operand's priority compare), is instantiated twice for A and B.

## Test plan
- RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 → ForwardAE=10. Repeat with RegWriteM=0 → ForwardAE=01. Repeat with RA1E=15 → ForwardAE=00.
- MemtoRegE=1, WA3E=5, RA2D=5 → StallF=StallD=FlushE=1, FlushD=0. Add BranchTakenE=1 → StallF=StallD=0, FlushD=FlushE=1.
- PCSrcD pulse in IDLE, PCSrcM=1 in cycle 2 → StallF=1,1,1,0 and FlushD=1,1,1,1 over cycles 0–3; IDLE in cycle 4.
- Same sequence with PCSrcM=0 → StallF=0 and FlushD=0 in cycle 3; IDLE.
- Reset pulled low while the FSM is in PCW_M → outputs take their reset values immediately; after release the FSM is IDLE and StallF=0.
- HAZARD_PERF_EN with CNTW=4: 20 consecutive StallD cycles → StallCount stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PCW_E = 2'd1,
    PCW_M = 2'd2,
    PCW_W = 2'd3
  } pcw_state_t;

  localparam logic [3:0] PC_REG = 4'hF;

endpackage

// File: rtl/hazard_if.sv
// Pipeline <-> hazard unit signal bundle. Counter signals exist only when
// HAZARD_PERF_EN is defined.
interface hazard_if #(
  parameter int REGW = 4,
  parameter int CNTW = 32
);
  logic [REGW-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REGW-1:0] WA3E, WA3M, WA3W;
  logic            RegWriteM, RegWriteW, MemtoRegE;
  logic            PCSrcD, PCSrcM, BranchTakenE;
  logic [1:0]      ForwardAE, ForwardBE;
  logic            StallF, StallD, FlushD, FlushE;
`ifdef HAZARD_PERF_EN
  logic [CNTW-1:0] StallCount, FlushCount;
`endif

  // pipeline side
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcM, BranchTakenE,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
`ifdef HAZARD_PERF_EN
    , input StallCount, FlushCount
`endif
  );

  // hazard unit side
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcM, BranchTakenE,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE
`ifdef HAZARD_PERF_EN
    , output StallCount, FlushCount
`endif
  );
endinterface

// File: rtl/hazard_unit_fwd_select.sv
// One operand's forwarding priority compare: Memory beats Writeback, R15 never forwards.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REGW = 4
) (
  input  logic [REGW-1:0] ra,
  input  logic [REGW-1:0] wa_m,
  input  logic [REGW-1:0] wa_w,
  input  logic            reg_write_m,
  input  logic            reg_write_w,
  output fwd_sel_t        sel
);
  localparam logic [REGW-1:0] PC_ADDR = REGW'(PC_REG);

  always_comb begin
    sel = FWD_RF;
    if (ra != PC_ADDR) begin
      if (reg_write_m && (ra == wa_m))      sel = FWD_MEM;
      else if (reg_write_w && (ra == wa_w)) sel = FWD_WB;
    end
  end
endmodule

// File: rtl/hazard_unit.sv
// Hazard controller: forwarding selects, load-use stall, branch flush and PC-write tracking FSM.
// Optional performance counters enabled by defining HAZARD_PERF_EN.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REGW = 4,
  parameter int CNTW = 32
) (
  input logic     clk,
  input logic     reset,
  hazard_if.slave bus
);
  pcw_state_t state, state_nxt;
  logic       ldr_stall, pcw_pend;
  fwd_sel_t   fwd [2];

  logic [1:0][REGW-1:0] ra_e;
  assign ra_e = {bus.RA2E, bus.RA1E};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    fwd_select #(.REGW(REGW)) u_fwd (
      .ra         (ra_e[i]),
      .wa_m       (bus.WA3M),
      .wa_w       (bus.WA3W),
      .reg_write_m(bus.RegWriteM),
      .reg_write_w(bus.RegWriteW),
      .sel        (fwd[i])
    );
  end

  assign ldr_stall = bus.MemtoRegE
                   & ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E))
                   & (state == IDLE);
  assign pcw_pend  = (state != IDLE)
                   | ((state == IDLE) & bus.PCSrcD & ~bus.BranchTakenE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A load-use stall or a taken branch defers acceptance; PCSrcD is re-sampled next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.PCSrcD && !ldr_stall && !bus.BranchTakenE) state_nxt = PCW_E;
      PCW_E:   state_nxt = PCW_M;
      PCW_M:   state_nxt = bus.PCSrcM ? PCW_W : IDLE;
      PCW_W:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset holds the pipeline flushed with no forwarding or stalls.
  always_comb begin
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_RF;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.FlushD    = 1'b1;
    bus.FlushE    = 1'b1;
    if (reset) begin
      bus.ForwardAE = fwd[0];
      bus.ForwardBE = fwd[1];
      bus.StallD    = ldr_stall & ~bus.BranchTakenE;
      bus.StallF    = (ldr_stall | (pcw_pend & (state != PCW_W))) & ~bus.BranchTakenE;
      bus.FlushD    = pcw_pend | bus.BranchTakenE;
      bus.FlushE    = ldr_stall | bus.BranchTakenE;
    end
  end

`ifdef HAZARD_PERF_EN
  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.StallCount <= '0;
      bus.FlushCount <= '0;
    end else begin
      if (bus.StallD && !(&bus.StallCount)) bus.StallCount <= bus.StallCount + 1'b1;
      if (bus.FlushE && !(&bus.FlushCount)) bus.FlushCount <= bus.FlushCount + 1'b1;
    end
  end
`endif

endmodule
